// File: rtl/mips_ctrl_pkg.sv
// Shared control-word definitions for the MIPS decoder and the control pipeline.
// Holds the 12-bit control-word bit positions and field ranges, the LdSize and
// forwarding-select codes, the bubble word, and small helpers used by both sides.
package mips_ctrl_pkg;

  localparam int unsigned CW   = 12;
  localparam int unsigned REGW = 5;

  // Field widths as presented per stage
  localparam int unsigned exW  = 4;
  localparam int unsigned memW = 6;
  localparam int unsigned wbW  = 2;

  // Field ranges inside the control word
  localparam int unsigned exHi  = 11;
  localparam int unsigned exLo  = 8;
  localparam int unsigned memHi = 7;
  localparam int unsigned memLo = 2;

  // Individual control bits
  localparam int unsigned bitRegDst   = 11;
  localparam int unsigned bitAluSrc   = 8;
  localparam int unsigned bitMemRead  = 6;
  localparam int unsigned bitMemWrite = 5;
  localparam int unsigned bitRegWrite = 1;
  localparam int unsigned bitMemToReg = 0;

  localparam logic [CW-1:0] BUBBLE = '0;

  typedef enum logic [1:0] {
    ldWord = 2'b00,
    ldByte = 2'b01,
    ldHalf = 2'b10
  } ldSize_e;

  typedef enum logic [1:0] {
    fwdRegFile = 2'b00,
    fwdMemWb   = 2'b01,
    fwdExMem   = 2'b10
  } fwdSel_e;

  // Instructions that do not write a register carry no meaningful RegDst/MemToReg;
  // forcing them low keeps the stored state deterministic.
  function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] w);
    logic [CW-1:0] s;
    s = w;
    if (!w[bitRegWrite]) begin
      s[bitRegDst]   = 1'b0;
      s[bitMemToReg] = 1'b0;
    end
    return s;
  endfunction

  // True when a (non-zero) destination is one of the registers the reader uses.
  function automatic logic regHit(input logic [REGW-1:0] dest,
                                  input logic [REGW-1:0] rs,
                                  input logic [REGW-1:0] rt,
                                  input logic            useRt);
    return (dest != '0) && ((dest == rs) || (useRt && (dest == rt)));
  endfunction

endpackage

// File: rtl/control_pipe_if.sv
// Handshake bundle between the decoder/datapath and control_pipe.
// in*  : ID-stage control word, rs, rt, destination, and MEM-stage branch-taken.
// out* : stall request, per-stage control fields, MEM/WB destination, forward selects.
// Modports: master (decoder/datapath side), slave (control_pipe).
interface control_pipe_if;
  import mips_ctrl_pkg::*;

  logic [CW-1:0]   inControl;
  logic [REGW-1:0] inRs;
  logic [REGW-1:0] inRt;
  logic [REGW-1:0] inDest;
  logic            inBranchTaken;
  logic            outStall;
  logic [exW-1:0]  outExCtrl;
  logic [memW-1:0] outMemCtrl;
  logic [wbW-1:0]  outWbCtrl;
  logic [REGW-1:0] outWbDest;
  logic [1:0]      outFwdA;
  logic [1:0]      outFwdB;

  modport master (
    output inControl, inRs, inRt, inDest, inBranchTaken,
    input  outStall, outExCtrl, outMemCtrl, outWbCtrl, outWbDest, outFwdA, outFwdB
  );

  modport slave (
    input  inControl, inRs, inRt, inDest, inBranchTaken,
    output outStall, outExCtrl, outMemCtrl, outWbCtrl, outWbDest, outFwdA, outFwdB
  );
endinterface

// File: rtl/hazard_unit.sv
// Combinational hazard detection and operand-forward selection.
// Inputs : ID-stage operand-use bits and rs/rt, ID/EX load/write flags, rs/rt/dest,
//          EX/MEM and MEM/WB write flags and dests, branch-taken.
// Outputs: stall (already masked by branch-taken), fwdA/fwdB operand selects.
// Build option FORWARDING_EN: forwarding muxes built, only load-use stalls;
// otherwise every pending EX or MEM write to a used source stalls and selects are 00.
module hazard_unit
  import mips_ctrl_pkg::*;
(
  input  logic            idAluSrc,
  input  logic            idMemWrite,
  input  logic [REGW-1:0] idRs,
  input  logic [REGW-1:0] idRt,
  input  logic            exMemRead,
  input  logic            exRegWrite,
  input  logic [REGW-1:0] exRs,
  input  logic [REGW-1:0] exRt,
  input  logic [REGW-1:0] exDest,
  input  logic            memRegWrite,
  input  logic [REGW-1:0] memDest,
  input  logic            wbRegWrite,
  input  logic [REGW-1:0] wbDest,
  input  logic            branchTaken,
  output logic            stall,
  output logic [1:0]      fwdA,
  output logic [1:0]      fwdB
);

  logic idUsesRt;
  logic loadUse;
  logic rawHazard;

`ifdef FORWARDING_EN
  // EX/MEM holds the younger result, so it wins over MEM/WB.
  function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src);
    fwdSel_e sel;
    sel = fwdRegFile;
    if (src != '0) begin
      if (memRegWrite && (memDest == src)) begin
        sel = fwdExMem;
      end else if (wbRegWrite && (wbDest == src)) begin
        sel = fwdMemWb;
      end
    end
    return sel;
  endfunction

  logic unusedNoFwd;
  assign unusedNoFwd = exRegWrite;
`else
  logic unusedFwd;
  assign unusedFwd = ^{exRs, exRt, wbRegWrite, wbDest};
`endif

  always_comb begin
    idUsesRt = ~idAluSrc | idMemWrite;
    loadUse  = exMemRead & regHit(exDest, idRs, idRt, idUsesRt);
`ifdef FORWARDING_EN
    rawHazard = loadUse;
    fwdA      = fwdSel(exRs);
    fwdB      = fwdSel(exRt);
`else
    // MEM/WB is excluded: the register file writes before it is read.
    rawHazard = loadUse
              | (exRegWrite  & regHit(exDest,  idRs, idRt, idUsesRt))
              | (memRegWrite & regHit(memDest, idRs, idRt, idUsesRt));
    fwdA      = fwdRegFile;
    fwdB      = fwdRegFile;
`endif
    // A taken branch flushes the ID instruction anyway, so holding it is pointless.
    stall = rawHazard & ~branchTaken;
  end

endmodule

// File: rtl/control_pipe.sv
// Control pipeline of the 5-stage MIPS core: stages the decoder's 12-bit control word
// and register numbers through ID/EX, EX/MEM and MEM/WB, inserts bubbles on hazards
// and flushes on taken branches.
// Ports: clk, rst (async, active-low), bus (control_pipe_if.slave) carrying the ID
// control word/rs/rt/dest, branch-taken, stall, per-stage fields and forward selects.
// Build option FORWARDING_EN enables operand forwarding (see hazard_unit).
module control_pipe
  import mips_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst,
  control_pipe_if.slave bus
);

  // ID/EX keeps the whole word; later stages keep only the fields still needed.
  logic [CW-1:0]        idExCtrlQ, idExCtrlD;
  logic [REGW-1:0]      idExRsQ, idExRsD;
  logic [REGW-1:0]      idExRtQ, idExRtD;
  logic [REGW-1:0]      idExDestQ, idExDestD;
  logic [memW+wbW-1:0]  exMemCtrlQ, exMemCtrlD;
  logic [REGW-1:0]      exMemDestQ, exMemDestD;
  logic [wbW-1:0]       memWbCtrlQ, memWbCtrlD;
  logic [REGW-1:0]      memWbDestQ, memWbDestD;
  logic                 stall;

  hazard_unit u_hazard (
    .idAluSrc    (bus.inControl[bitAluSrc]),
    .idMemWrite  (bus.inControl[bitMemWrite]),
    .idRs        (bus.inRs),
    .idRt        (bus.inRt),
    .exMemRead   (idExCtrlQ[bitMemRead]),
    .exRegWrite  (idExCtrlQ[bitRegWrite]),
    .exRs        (idExRsQ),
    .exRt        (idExRtQ),
    .exDest      (idExDestQ),
    .memRegWrite (exMemCtrlQ[bitRegWrite]),
    .memDest     (exMemDestQ),
    .wbRegWrite  (memWbCtrlQ[bitRegWrite]),
    .wbDest      (memWbDestQ),
    .branchTaken (bus.inBranchTaken),
    .stall       (stall),
    .fwdA        (bus.outFwdA),
    .fwdB        (bus.outFwdB)
  );

  always_comb begin
    idExCtrlD  = sanitise(bus.inControl);
    idExRsD    = bus.inRs;
    idExRtD    = bus.inRt;
    idExDestD  = bus.inDest;
    exMemCtrlD = idExCtrlQ[memHi:0];
    exMemDestD = idExDestQ;
    memWbCtrlD = exMemCtrlQ[wbW-1:0];
    memWbDestD = exMemDestQ;

    // stall is already low during a flush, so flush always selects the bubble here too.
    if (bus.inBranchTaken || stall) begin
      idExCtrlD = BUBBLE;
      idExRsD   = '0;
      idExRtD   = '0;
      idExDestD = '0;
    end
    if (bus.inBranchTaken) begin
      exMemCtrlD = '0;
      exMemDestD = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idExCtrlQ  <= BUBBLE;
      idExRsQ    <= '0;
      idExRtQ    <= '0;
      idExDestQ  <= '0;
      exMemCtrlQ <= '0;
      exMemDestQ <= '0;
      memWbCtrlQ <= '0;
      memWbDestQ <= '0;
    end else begin
      idExCtrlQ  <= idExCtrlD;
      idExRsQ    <= idExRsD;
      idExRtQ    <= idExRtD;
      idExDestQ  <= idExDestD;
      exMemCtrlQ <= exMemCtrlD;
      exMemDestQ <= exMemDestD;
      memWbCtrlQ <= memWbCtrlD;
      memWbDestQ <= memWbDestD;
    end
  end

  assign bus.outStall   = stall;
  assign bus.outExCtrl  = idExCtrlQ[exHi:exLo];
  assign bus.outMemCtrl = exMemCtrlQ[memHi:memLo];
  assign bus.outWbCtrl  = memWbCtrlQ;
  assign bus.outWbDest  = memWbDestQ;

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: an instruction-level model of the pipe,
// compared on every falling edge, plus directed scenarios with literal expectations.
module tb_control_pipe;
  import mips_ctrl_pkg::*;

`ifdef FORWARDING_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_pipe_if bus ();

  control_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nCmp = 0;
  int nBad = 0;
  bit checkOn = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: instructions in flight, stage 1 = EX, 2 = MEM, 3 = WB -------------
  logic [11:0] mCtrl [1:3];
  logic [4:0]  mDest [1:3];
  logic [4:0]  mRs, mRt;

  function automatic bit idReads(input logic [4:0] r);
    bit readsRt;
    readsRt = !bus.inControl[8] || bus.inControl[5];
    return (r != 5'd0) && ((r == bus.inRs) || (readsRt && (r == bus.inRt)));
  endfunction

  // ID instruction cannot get its operand in time
  function automatic bit mHazard();
    bit h;
    h = mCtrl[1][6] && idReads(mDest[1]);
    if (!Fwd) begin
      for (int s = 1; s <= 2; s++) begin
        if (mCtrl[s][1] && idReads(mDest[s])) h = 1'b1;
      end
    end
    return h;
  endfunction

  function automatic logic [1:0] mFwd(input logic [4:0] src);
    if (!Fwd || src == 5'd0) return 2'b00;
    if (mCtrl[2][1] && mDest[2] == src) return 2'b10;
    if (mCtrl[3][1] && mDest[3] == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 1; s <= 3; s++) begin
        mCtrl[s] <= '0;
        mDest[s] <= '0;
      end
      mRs <= '0;
      mRt <= '0;
    end else begin
      mCtrl[3] <= mCtrl[2];
      mDest[3] <= mDest[2];
      mCtrl[2] <= bus.inBranchTaken ? 12'd0 : mCtrl[1];
      mDest[2] <= bus.inBranchTaken ? 5'd0 : mDest[1];
      if (bus.inBranchTaken || mHazard()) begin
        mCtrl[1] <= '0;
        mDest[1] <= '0;
        mRs      <= '0;
        mRt      <= '0;
      end else begin
        mCtrl[1] <= bus.inControl;
        mDest[1] <= bus.inDest;
        mRs      <= bus.inRs;
        mRt      <= bus.inRt;
      end
    end
  end

  // Model stores raw words; a non-writing instruction shows RegDst and MemToReg as 0.
  always @(negedge clk) begin
    if (checkOn) begin
      cmp("m_stall", 32'(bus.outStall), 32'(!bus.inBranchTaken && mHazard()));
      cmp("m_ex", 32'(bus.outExCtrl), 32'({mCtrl[1][11] & mCtrl[1][1], mCtrl[1][10:8]}));
      cmp("m_mem", 32'(bus.outMemCtrl), 32'(mCtrl[2][7:2]));
      cmp("m_wb", 32'(bus.outWbCtrl), 32'({mCtrl[3][1], mCtrl[3][1] & mCtrl[3][0]}));
      cmp("m_wbdest", 32'(bus.outWbDest), 32'(mDest[3]));
      cmp("m_fwdA", 32'(bus.outFwdA), 32'(mFwd(mRs)));
      cmp("m_fwdB", 32'(bus.outFwdB), 32'(mFwd(mRt)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setIn(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] d, input logic br);
    bus.inControl     = c;
    bus.inRs          = rs;
    bus.inRt          = rt;
    bus.inDest        = d;
    bus.inBranchTaken = br;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, hold it while stalled, return after it is captured.
  task automatic issue(input logic [11:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] d, output int stalls);
    bit took;
    took   = 1'b0;
    stalls = 0;
    setIn(c, rs, rt, d, 1'b0);
    for (int n = 0; n < 8 && !took; n++) begin
      @(negedge clk);
      if (bus.outStall) stalls++;
      else took = 1'b1;
      nextCycle();
    end
    if (!took) begin
      nCmp++;
      nBad++;
      $display("FAIL issue_timeout: stalled %0d cycles, required acceptance", stalls);
    end
    setIn(12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  function automatic logic [21:0] allOut();
    return {bus.outStall, bus.outExCtrl, bus.outMemCtrl, bus.outWbCtrl, bus.outWbDest,
            bus.outFwdA, bus.outFwdB};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: run did not end, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    setIn(12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    checkOn = 1'b1;
    @(negedge clk);
    cmp("reset_outputs", 32'(allOut()), 32'd0);
    nextCycle();
    rst = 1'b1;

    // R-type, dest 8: latencies 1/2/3
    issue(12'hC02, 5'd1, 5'd2, 5'd8, st);
    cmp("rtype_stalls", 32'(st), 32'd0);
    @(negedge clk);
    cmp("rtype_ex", 32'(bus.outExCtrl), 32'hC);
    nextCycle();
    @(negedge clk);
    cmp("rtype_mem", 32'(bus.outMemCtrl), 32'h0);
    nextCycle();
    @(negedge clk);
    cmp("rtype_wb", 32'(bus.outWbCtrl), 32'b10);
    cmp("rtype_wbdest", 32'(bus.outWbDest), 32'd8);
    repeat (3) nextCycle();

    // Load-use: LW r9 then R-type reading rs=9
    issue(12'h143, 5'd3, 5'd0, 5'd9, st);
    setIn(12'hC02, 5'd9, 5'd4, 5'd11, 1'b0);
    @(negedge clk);
    cmp("lu_stall", 32'(bus.outStall), 32'd1);
    nextCycle();
    @(negedge clk);
    cmp("lu_bubble", 32'(bus.outExCtrl), 32'h0);
    cmp("lu_mem", 32'(bus.outMemCtrl), 32'h10);
    cmp("lu_stall2", 32'(bus.outStall), Fwd ? 32'd0 : 32'd1);
    nextCycle();
    if (!Fwd) begin
      @(negedge clk);
      cmp("lu_stall3", 32'(bus.outStall), 32'd0);
      nextCycle();
    end
    setIn(12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    cmp("lu_ex", 32'(bus.outExCtrl), 32'hC);
    cmp("lu_fwdA", 32'(bus.outFwdA), Fwd ? 32'b01 : 32'b00);
    repeat (3) nextCycle();

    // RAW on rt between back-to-back R-types
    issue(12'hC02, 5'd1, 5'd2, 5'd10, st);
    issue(12'hC02, 5'd5, 5'd10, 5'd12, st);
    cmp("raw_stalls", 32'(st), Fwd ? 32'd0 : 32'd2);
    @(negedge clk);
    cmp("raw_fwdB", 32'(bus.outFwdB), Fwd ? 32'b10 : 32'b00);
    repeat (3) nextCycle();

    // Taken branch coinciding with a load-use hazard
    issue(12'hC02, 5'd1, 5'd2, 5'd8, st);
    issue(12'h143, 5'd3, 5'd0, 5'd9, st);
    setIn(12'hC02, 5'd9, 5'd4, 5'd11, 1'b1);
    @(negedge clk);
    cmp("flush_stall", 32'(bus.outStall), 32'd0);
    nextCycle();
    setIn(12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    cmp("flush_ex", 32'(bus.outExCtrl), 32'h0);
    cmp("flush_mem", 32'(bus.outMemCtrl), 32'h0);
    cmp("flush_wb", 32'(bus.outWbCtrl), 32'b10);
    cmp("flush_wbdest", 32'(bus.outWbDest), 32'd8);
    repeat (3) nextCycle();

    // r0 never creates a hazard or a forward
    issue(12'h143, 5'd3, 5'd0, 5'd0, st);
    issue(12'hC02, 5'd0, 5'd0, 5'd13, st);
    cmp("r0_load_stalls", 32'(st), 32'd0);
    issue(12'hC02, 5'd1, 5'd2, 5'd0, st);
    issue(12'hC02, 5'd0, 5'd0, 5'd14, st);
    cmp("r0_r_stalls", 32'(st), 32'd0);
    @(negedge clk);
    cmp("r0_fwd", 32'({bus.outFwdA, bus.outFwdB}), 32'd0);
    repeat (3) nextCycle();

    // Non-writing word with RegDst/MemToReg set gets sanitised
    issue(12'h801, 5'd1, 5'd2, 5'd7, st);
    @(negedge clk);
    cmp("san_ex", 32'(bus.outExCtrl), 32'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    cmp("san_wb", 32'(bus.outWbCtrl), 32'b00);
    repeat (2) nextCycle();

    // Store
    issue(12'h024, 5'd2, 5'd3, 5'd5, st);
    nextCycle();
    @(negedge clk);
    cmp("st_mem", 32'(bus.outMemCtrl), 32'h09);
    nextCycle();
    @(negedge clk);
    cmp("st_wb", 32'(bus.outWbCtrl), 32'b00);
    cmp("st_nox", 32'($isunknown(allOut())), 32'd0);
    repeat (2) nextCycle();

    // Asynchronous reset with the pipe full
    issue(12'hC02, 5'd1, 5'd2, 5'd8, st);
    issue(12'h143, 5'd1, 5'd2, 5'd9, st);
    #2;
    rst = 1'b0;
    #1;
    cmp("async_reset", 32'(allOut()), 32'd0);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    cmp("post_reset", 32'(allOut()), 32'd0);
    issue(12'hC02, 5'd1, 5'd2, 5'd8, st);
    @(negedge clk);
    cmp("post_reset_ex", 32'(bus.outExCtrl), 32'hC);
    cmp("post_reset_wb", 32'(bus.outWbCtrl), 32'b00);
    repeat (4) nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
